// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit-side blocks and their benches.
//
//   UART_DATA_WIDTH      : character width used by uart_tx and its FIFO.
//   uart_tx_fifo_state_t : launch/handshake states of the TX FIFO drain FSM.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } uart_tx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
//   Simple dual-port register array used as FIFO storage. It has one
//   synchronous write port and one asynchronous (combinational) read port.
//   It holds no pointers or flags, so TX and RX FIFOs can both reuse it.
//
//   Ports:
//     clk      in   write clock
//     wr_en    in   write enable, sampled on rising edge
//     wr_addr  in   ADDR_WIDTH  write address
//     wr_data  in   DATA_WIDTH  write data
//     rd_addr  in   ADDR_WIDTH  read address
//     rd_data  out  DATA_WIDTH  contents of rd_addr (combinational)
// -----------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int  DATA_WIDTH = UART_DATA_WIDTH,
  parameter int  DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage is deliberately not reset. Readers only look at entries
  // that a write has already filled.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit byte buffer placed directly upstream of uart_tx.
//   - Bursty host writes are queued in a circular FIFO.
//   - Bytes are drained into uart_tx one frame at a time through its
//     start/done/busy handshake.
//
//   Optional feature macro: UART_TX_FIFO_LEVEL_EN
//     When defined, adds the o_level port, driven by a registered
//     occupancy counter.
//
//   Ports:
//     i_clk       in   system clock, rising edge
//     i_rst_n     in   asynchronous active-low reset
//     i_wr_en     in   host write strobe
//     i_wr_data   in   DATA_WIDTH  byte to enqueue
//     o_full      out  FIFO holds DEPTH entries
//     o_empty     out  FIFO holds no entries
//     o_overflow  out  one-cycle pulse; a write was dropped because the FIFO was full
//     o_tx_start  out  one-cycle launch pulse to uart_tx.i_start
//     o_tx_data   out  DATA_WIDTH  byte to uart_tx.i_data; held until next launch
//     i_tx_done   in   uart_tx.o_done
//     i_tx_busy   in   uart_tx.o_busy
//     o_level     out  ADDR_WIDTH+1  occupancy (only with UART_TX_FIFO_LEVEL_EN)
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  DATA_WIDTH = UART_DATA_WIDTH,
  parameter int  DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_done,
  input  logic                  i_tx_busy
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   o_level
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  // The pointers carry one extra wrap bit. That bit lets full and empty
  // be told apart when the address bits match.
  logic [ADDR_WIDTH:0]     wr_ptr;
  logic [ADDR_WIDTH:0]     rd_ptr;
  logic [DATA_WIDTH-1:0]   rd_data;

  logic                    wr_acc;
  logic                    pop;
  logic                    done_q;
  logic                    done_rise;
  logic                    overflow_q;
  logic                    tx_start_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;

  uart_tx_fifo_state_t     state;
  uart_tx_fifo_state_t     state_next;

  // Flags depend only on the pointer registers. They therefore show every
  // write and pop from the previous edge.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  // A pop in the same cycle does not make room. Acceptance looks only at
  // the registered full flag.
  assign wr_acc    = i_wr_en && !o_full;
  assign done_rise = i_tx_done && !done_q;

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (i_wr_data),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  // Drain FSM, next-state logic.
  // Gating on i_tx_busy matters after a mid-frame reset. uart_tx keeps
  // sending its current frame, so no new launch may start until that
  // frame has finished.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!o_empty && !i_tx_busy) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stage boundary: state, pointers, done edge detector and launch outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state      <= state_next;
      done_q     <= i_tx_done;
      overflow_q <= i_wr_en && o_full;
      tx_start_q <= pop;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        tx_data_q <= rd_data;
      end
    end
  end

  assign o_overflow = overflow_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q;

  // Stage boundary: occupancy counter, kept in step with the pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= '0;
    end else begin
      unique case ({wr_acc, pop})
        2'b10:   level_q <= level_q + PTR_ONE;
        2'b01:   level_q <= level_q - PTR_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  assign o_level = level_q;
`endif

endmodule
